// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter.
//   state_e - arbiter FSM encoding (idle, M access in flight, DMA access in flight)
//   AddrW   - word address width of the data-memory bus
//   DataW   - data width of the data-memory bus
package dmem_pkg;

  localparam int unsigned AddrW = 30;
  localparam int unsigned DataW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    M_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_starve_ctr.sv
// dmem_starve_ctr: saturating count of M grants taken while DMA was waiting.
//   clk_i, rst_ni - clock and asynchronous active-low reset
//   inc_i         - M grant while DMA waits (saturates at Limit)
//   clr_i         - DMA grant, or M grant with no DMA waiting (wins over inc_i)
//   at_limit_o    - count has reached Limit; DMA must win the next grant
module dmem_starve_ctr #(
  parameter int unsigned Limit = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);
  localparam logic [CntW-1:0] LimitC = CntW'(Limit);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LimitC)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LimitC);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory bus between the M-stage load/store path
// and a DMA requester, one registered request/acknowledge access at a time.
//   clock, reset          - clock and asynchronous active-low reset
//   M_*  (in)             - M-stage access fields; M_Hold = stage frozen elsewhere
//   M_Stall, M_ReadData   - memory-stage stall and registered load data
//   D_*  (in)             - DMA access fields; D_Req held until D_Ack
//   D_Ack, D_ReadData     - one-cycle DMA completion pulse and registered read data
//   Mem_* (out)           - registered bus request and fields
//   Mem_Ack, Mem_ReadData - bus completion and read data
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             M_Req,
  input  logic             M_Write,
  input  logic [AddrW-1:0] M_Addr,
  input  logic [DataW-1:0] M_WriteData,
  input  logic [3:0]       M_ByteEn,
  input  logic             M_Hold,
  output logic             M_Stall,
  output logic [DataW-1:0] M_ReadData,
  input  logic             D_Req,
  input  logic             D_Write,
  input  logic [AddrW-1:0] D_Addr,
  input  logic [DataW-1:0] D_WriteData,
  input  logic [3:0]       D_ByteEn,
  output logic             D_Ack,
  output logic [DataW-1:0] D_ReadData,
  output logic             Mem_Req,
  output logic             Mem_Write,
  output logic [AddrW-1:0] Mem_Addr,
  output logic [DataW-1:0] Mem_WriteData,
  output logic [3:0]       Mem_ByteEn,
  input  logic             Mem_Ack,
  input  logic [DataW-1:0] Mem_ReadData
);

  state_e           state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_write_q, mem_write_d;
  logic [AddrW-1:0] mem_addr_q, mem_addr_d;
  logic [DataW-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [DataW-1:0] m_rdata_q, m_rdata_d;
  logic [DataW-1:0] d_rdata_q, d_rdata_d;
  logic             m_done_q, m_done_d;
  logic             d_pend_q, d_pend_d;
  logic             d_ack_q, d_ack_d;

  logic m_elig, d_elig, grant_m, grant_d, at_limit;

  // A finished DMA access keeps D_Req high until its D_Ack; d_pend blocks
  // that stale request from being granted again or counted as waiting.
  assign m_elig = M_Req & ~m_done_q;
  assign d_elig = D_Req & ~d_pend_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    m_rdata_d   = m_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_m     = 1'b0;
    grant_d     = 1'b0;
    // m_done survives only while the pipeline is frozen by another source.
    m_done_d    = m_done_q & M_Hold;
    // Completion -> pend for one cycle -> D_Ack pulse while still pending.
    d_ack_d     = d_pend_q & ~d_ack_q;
    d_pend_d    = d_pend_q & ~d_ack_q;

    unique case (state_q)
      IDLE: begin
        if (m_elig && (!d_elig || !at_limit)) begin
          grant_m     = 1'b1;
          state_d     = M_BUSY;
          mem_req_d   = 1'b1;
          mem_write_d = M_Write;
          mem_addr_d  = M_Addr;
          mem_wdata_d = M_WriteData;
          mem_be_d    = M_ByteEn;
        end else if (d_elig) begin
          grant_d     = 1'b1;
          state_d     = D_BUSY;
          mem_req_d   = 1'b1;
          mem_write_d = D_Write;
          mem_addr_d  = D_Addr;
          mem_wdata_d = D_WriteData;
          mem_be_d    = D_ByteEn;
        end
      end
      M_BUSY: begin
        if (Mem_Ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          m_rdata_d = Mem_ReadData;
          m_done_d  = 1'b1;
        end
      end
      D_BUSY: begin
        if (Mem_Ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_rdata_d = Mem_ReadData;
          d_pend_d  = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      m_rdata_q   <= '0;
      d_rdata_q   <= '0;
      m_done_q    <= 1'b0;
      d_pend_q    <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      m_rdata_q   <= m_rdata_d;
      d_rdata_q   <= d_rdata_d;
      m_done_q    <= m_done_d;
      d_pend_q    <= d_pend_d;
      d_ack_q     <= d_ack_d;
    end
  end

  dmem_starve_ctr #(
    .Limit (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk_i      (clock),
    .rst_ni     (reset),
    .inc_i      (grant_m & d_elig),
    .clr_i      (grant_d | (grant_m & ~d_elig)),
    .at_limit_o (at_limit)
  );

  assign M_Stall       = M_Req & ~m_done_q;
  assign M_ReadData    = m_rdata_q;
  assign D_Ack         = d_ack_q;
  assign D_ReadData    = d_rdata_q;
  assign Mem_Req       = mem_req_q;
  assign Mem_Write     = mem_write_q;
  assign Mem_Addr      = mem_addr_q;
  assign Mem_WriteData = mem_wdata_q;
  assign Mem_ByteEn    = mem_be_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int LIMIT = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        M_Req, M_Write, M_Hold;
  logic [29:0] M_Addr;
  logic [31:0] M_WriteData;
  logic [3:0]  M_ByteEn;
  logic        M_Stall;
  logic [31:0] M_ReadData;
  logic        D_Req, D_Write;
  logic [29:0] D_Addr;
  logic [31:0] D_WriteData;
  logic [3:0]  D_ByteEn;
  logic        D_Ack;
  logic [31:0] D_ReadData;
  logic        Mem_Req, Mem_Write;
  logic [29:0] Mem_Addr;
  logic [31:0] Mem_WriteData;
  logic [3:0]  Mem_ByteEn;
  logic        Mem_Ack;
  logic [31:0] Mem_ReadData;

  always #5 clock = ~clock;

  dmem_arbiter #(
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .M_Req         (M_Req),
    .M_Write       (M_Write),
    .M_Addr        (M_Addr),
    .M_WriteData   (M_WriteData),
    .M_ByteEn      (M_ByteEn),
    .M_Hold        (M_Hold),
    .M_Stall       (M_Stall),
    .M_ReadData    (M_ReadData),
    .D_Req         (D_Req),
    .D_Write       (D_Write),
    .D_Addr        (D_Addr),
    .D_WriteData   (D_WriteData),
    .D_ByteEn      (D_ByteEn),
    .D_Ack         (D_Ack),
    .D_ReadData    (D_ReadData),
    .Mem_Req       (Mem_Req),
    .Mem_Write     (Mem_Write),
    .Mem_Addr      (Mem_Addr),
    .Mem_WriteData (Mem_WriteData),
    .Mem_ByteEn    (Mem_ByteEn),
    .Mem_Ack       (Mem_Ack),
    .Mem_ReadData  (Mem_ReadData)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: who owns the bus, whether the current M instruction has
  // been served, DMA ack countdown and the starvation count.
  int          mo_owner;     // 0 none, 1 M, 2 D
  bit          mo_m_done;
  int          mo_d_phase;   // 2: completed, 1: acking, 0: free
  int          mo_starve;
  logic        mo_req, mo_wr, mo_dack;
  logic [29:0] mo_addr;
  logic [31:0] mo_wd, mo_mrd, mo_drd;
  logic [3:0]  mo_be;
  int          model_log[$];
  int          dut_log[$];
  int          wr_count;

  function automatic void model_reset();
    mo_owner = 0; mo_m_done = 0; mo_d_phase = 0; mo_starve = 0;
    mo_req = 0; mo_wr = 0; mo_dack = 0; mo_addr = '0; mo_wd = '0;
    mo_mrd = '0; mo_drd = '0; mo_be = '0;
  endfunction

  function automatic void model_step();
    bit m_ok, d_ok, nxt_done;
    int nxt_phase;
    m_ok      = M_Req && !mo_m_done;
    d_ok      = D_Req && (mo_d_phase == 0);
    nxt_done  = mo_m_done && M_Hold;
    mo_dack   = (mo_d_phase == 2);
    nxt_phase = (mo_d_phase > 0) ? mo_d_phase - 1 : 0;
    case (mo_owner)
      0: begin
        if (m_ok && (!d_ok || mo_starve < LIMIT)) begin
          mo_owner = 1; mo_req = 1; mo_wr = M_Write; mo_addr = M_Addr;
          mo_wd = M_WriteData; mo_be = M_ByteEn;
          model_log.push_back(1);
          mo_starve = d_ok ? ((mo_starve < LIMIT) ? mo_starve + 1 : LIMIT) : 0;
        end else if (d_ok) begin
          mo_owner = 2; mo_req = 1; mo_wr = D_Write; mo_addr = D_Addr;
          mo_wd = D_WriteData; mo_be = D_ByteEn;
          model_log.push_back(2);
          mo_starve = 0;
        end
      end
      1: if (Mem_Ack) begin
        mo_owner = 0; mo_req = 0; mo_mrd = Mem_ReadData; nxt_done = 1;
      end
      default: if (Mem_Ack) begin
        mo_owner = 0; mo_req = 0; mo_drd = Mem_ReadData; nxt_phase = 2;
      end
    endcase
    mo_m_done  = nxt_done;
    mo_d_phase = nxt_phase;
  endfunction

  task automatic check_outputs();
    check("M_Stall", M_Stall, M_Req & ~mo_m_done);
    check("Mem_Req", Mem_Req, mo_req);
    if (mo_req) begin
      check("Mem_Write", Mem_Write, mo_wr);
      check("Mem_Addr", Mem_Addr, mo_addr);
      check("Mem_WriteData", Mem_WriteData, mo_wd);
      check("Mem_ByteEn", Mem_ByteEn, mo_be);
    end
    check("M_ReadData", M_ReadData, mo_mrd);
    check("D_ReadData", D_ReadData, mo_drd);
    check("D_Ack", D_Ack, mo_dack);
  endtask

  // Called at posedge+1 with this cycle's inputs applied.
  task automatic cycle();
    logic prev_req;
    #1;
    check_outputs();
    prev_req = Mem_Req;
    if (Mem_Req && Mem_Ack && Mem_Write) wr_count++;
    @(posedge clock);
    if (reset) model_step();
    else model_reset();
    #1;
    if (reset && Mem_Req && !prev_req) dut_log.push_back((Mem_Addr == D_Addr) ? 2 : 1);
  endtask

  task automatic clear_inputs();
    M_Req = 0; M_Write = 0; M_Addr = '0; M_WriteData = '0; M_ByteEn = '0; M_Hold = 0;
    D_Req = 0; D_Write = 0; D_Addr = '0; D_WriteData = '0; D_ByteEn = '0;
    Mem_Ack = 0; Mem_ReadData = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_Mem_Req", Mem_Req, 1'b0);
    check("rst_D_Ack", D_Ack, 1'b0);
    check("rst_M_ReadData", M_ReadData, 32'h0);
    check("rst_D_ReadData", D_ReadData, 32'h0);
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    model_reset();
    #1;
  endtask

  typedef struct {
    logic        m_req;
    logic        d_req;
    logic        mem_ack;
    logic [31:0] rdata;
    logic        e_stall;
    logic        e_mreq;
    logic [29:0] e_addr;
    logic        e_dack;
    logic [31:0] e_mrd;
    logic [31:0] e_drd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int run, max_run, d_grants;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 30'h0,   1'b0, 32'h0,        32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 30'h100, 1'b0, 32'h0,        32'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 30'h0,   1'b0, 32'hDEADBEEF, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 30'h0,   1'b0, 32'hDEADBEEF, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 30'h0,   1'b0, 32'hDEADBEEF, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b1, 30'h200, 1'b0, 32'hDEADBEEF, 32'h0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 30'h0,   1'b0, 32'hDEADBEEF, 32'h12345678};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 30'h0,   1'b1, 32'hDEADBEEF, 32'h12345678};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 30'h0,   1'b0, 32'hDEADBEEF, 32'h12345678};

    // Directed table: M load with same-cycle ack, then a DMA read.
    do_reset();
    M_Addr = 30'h100;
    D_Addr = 30'h200;
    for (int i = 0; i < 9; i++) begin
      M_Req        = tbl[i].m_req;
      D_Req        = tbl[i].d_req;
      Mem_Ack      = tbl[i].mem_ack;
      Mem_ReadData = tbl[i].rdata;
      #1;
      check($sformatf("tbl%0d_M_Stall", i), M_Stall, tbl[i].e_stall);
      check($sformatf("tbl%0d_Mem_Req", i), Mem_Req, tbl[i].e_mreq);
      if (tbl[i].e_mreq) check($sformatf("tbl%0d_Mem_Addr", i), Mem_Addr, tbl[i].e_addr);
      check($sformatf("tbl%0d_D_Ack", i), D_Ack, tbl[i].e_dack);
      check($sformatf("tbl%0d_M_ReadData", i), M_ReadData, tbl[i].e_mrd);
      check($sformatf("tbl%0d_D_ReadData", i), D_ReadData, tbl[i].e_drd);
      @(posedge clock);
      #1;
    end

    // M write, bus ack after 3 wait cycles, then M_Hold for 2 cycles.
    do_reset();
    wr_count = 0;
    M_Req = 1; M_Write = 1; M_Addr = 30'h0ABC; M_WriteData = 32'hCAFEF00D; M_ByteEn = 4'b0110;
    cycle();
    repeat (3) cycle();
    Mem_Ack = 1;
    cycle();
    Mem_Ack = 0; M_Hold = 1;
    repeat (2) cycle();
    M_Hold = 0;
    cycle();
    M_Req = 0;
    repeat (2) cycle();
    check("single_bus_write", wr_count, 32'd1);

    // Reset asserted while an M access is in flight.
    do_reset();
    M_Req = 1; M_Addr = 30'h155;
    cycle();
    check("pre_rst_Mem_Req", Mem_Req, 1'b1);
    reset = 0;
    #1;
    check("mid_rst_Mem_Req", Mem_Req, 1'b0);
    check("mid_rst_Mem_Addr", Mem_Addr, 32'h0);
    check("mid_rst_M_Stall", M_Stall, 1'b1);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    model_step();
    #1;
    check("reissue_Mem_Req", Mem_Req, 1'b1);
    check("reissue_Mem_Addr", Mem_Addr, 32'h155);
    Mem_Ack = 1; Mem_ReadData = 32'hA5A5_0001;
    cycle();
    Mem_Ack = 0; M_Req = 0;
    repeat (2) cycle();

    // Both requesters held high, bus acks every cycle.
    do_reset();
    model_log.delete();
    dut_log.delete();
    M_Addr = 30'h111; D_Addr = 30'h222;
    M_Req = 1; D_Req = 1; Mem_Ack = 1; Mem_ReadData = 32'h0BAD_F00D;
    repeat (60) cycle();
    check("grant_count", dut_log.size(), model_log.size());
    for (int i = 0; i < dut_log.size() && i < model_log.size(); i++)
      check($sformatf("grant%0d", i), dut_log[i], model_log[i]);
    run = 0; max_run = 0; d_grants = 0;
    foreach (dut_log[i]) begin
      if (dut_log[i] == 1) run++;
      else begin run = 0; d_grants++; end
      if (run > max_run) max_run = run;
    end
    check("dma_progress", (d_grants > 0), 1'b1);
    check("m_run_bounded", (max_run <= LIMIT), 1'b1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      M_Req        = ($urandom_range(0, 3) != 0);
      M_Write      = 1'($urandom());
      M_Addr       = 30'($urandom());
      M_WriteData  = $urandom();
      M_ByteEn     = 4'($urandom());
      M_Hold       = ($urandom_range(0, 3) == 0);
      if (!D_Req || D_Ack) begin
        D_Req       = ($urandom_range(0, 2) == 0);
        D_Write     = 1'($urandom());
        D_Addr      = 30'($urandom());
        D_WriteData = $urandom();
        D_ByteEn    = 4'($urandom());
      end
      Mem_Ack      = 1'($urandom());
      Mem_ReadData = $urandom();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
